vec_mem_seq: RTL
================

# vec_mem_seq

Vector memory sequencer for the multicycle processor's vector extension.
- Performs the byte-serial memory transfers behind vector load (4 bytes from memory into one 32-bit vector word, then a VRF write pulse) and vector store (one 32-bit vector word out to 4 consecutive memory bytes).
- Sits between the control FSM and the single-port 8-bit data memory.
- Replaces the ad-hoc T0–T3 staging registers and the memory-input mux with one self-timed unit.

## Interface
Parameters:
- ELEMS, 4, vector elements per word; fixed at 4 for this design.
- ELEM_W, 8, element and memory data width.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; takes effect on the rising edge of clock.
- start  in  1  request pulse; sampled only in IDLE.
- op_store  in  1  0 = vector load, 1 = vector store; sampled with start.
- base_addr  in  8  byte address of element 0; sampled with start.
- vdata_in  in  32  store data; sampled with start.
- mem_q  in  8  memory read data; valid one cycle after mem_read with an address.
- mem_addr  out  8  memory address.
- mem_read  out  1  memory read enable.
- mem_wren  out  1  memory write enable.
- mem_data  out  8  memory write data.
- vdata_out  out  32  assembled load word; drives VRF vdataw.
- vrf_write  out  1  one-cycle VRF write strobe.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.

## Operation
Element mapping:
- Element i lives at address base_addr+i, modulo 256.
- Element i occupies vector bits [8i+7:8i].

States and transitions:
- IDLE → LD when start=1 and op_store=0; → ST when start=1 and op_store=1. Latch base_addr and vdata_in; set idx=0.
- LD: mem_read=1, mem_addr=base+idx. If idx≠0, capture mem_q into byte idx-1 of vdata_out. idx increments each cycle; after idx=3, go to LD_DRAIN.
- LD_DRAIN: capture mem_q into byte 3; mem_read=0. Go to WB.
- WB: vrf_write=1, done=1. Go to IDLE.
- ST: mem_wren=1, mem_addr=base+idx, mem_data=latched byte idx. After idx=3, go to ST_DONE.
- ST_DONE: done=1; mem_wren=0. Go to IDLE.

Rules:
- mem_read and mem_wren are never high together.
- Outside LD and ST: mem_addr=0 and mem_data=0.
- start while busy is ignored; it is neither queued nor able to corrupt the latched operands.
- vdata_out holds its last assembled value until the next load's first capture; a store never modifies it.
- Address arithmetic is 8-bit and wraps: base 0xFE accesses 0xFE, 0xFF, 0x00, 0x01.

## Timing
- Reset values: state IDLE, idx 0, every output 0, vdata_out 0x00000000.
- Reset mid-operation: back to IDLE on the next edge. No further memory write occurs, and neither vrf_write nor done is issued.
- Load latency: start accepted at edge E0.
  - LD occupies cycles E0..E4.
  - LD_DRAIN occupies E4..E5.
  - WB (vrf_write and done) is the cycle after edge E5.
  - vdata_out is final when vrf_write is high.
- Store latency: 4 write cycles after E0; done is high in the 5th cycle.
- A new start is accepted in the cycle done is high only after the return to IDLE, i.e. the earliest new start is sampled at the edge that ends the done cycle + 1.

## Configuration
Macro VEC_MEM_SEQ_POSTINC_EN.
- Defined: adds two output ports.
  - addr_next [7:0]: (base+4) mod 256, valid while done is high, 0 otherwise.
  - addr_wb [0:0]: equals done. The control FSM uses it to write addr_next back to the scalar base register (post-increment addressing).
- Undefined: neither port exists and no adder is built. All other behaviour is identical.

## Structure
- Package vec_mem_pkg holds:
  - the state enum (IDLE, LD, LD_DRAIN, WB, ST, ST_DONE);
  - constants VEC_ELEMS=4 and VEC_ELEM_W=8;
  - the element-index type (2 bits).
- One sub-module, vec_byte_slots: a 4×8 register with an indexed byte write enable and an indexed byte read. Two instances are used:
  - one as the load assembly buffer, driving vdata_out;
  - one as the store source buffer, loaded in one cycle at start.

## Test plan
- Load, base 0x10, memory 10:AA 11:BB 12:CC 13:DD → mem_read on 0x10..0x13 in consecutive cycles; vrf_write in the 6th cycle after start with vdata_out=0xDDCCBBAA; done coincident.
- Store, base 0x20, vdata_in 0x44332211 → mem_wren for 4 cycles writing 20:11 21:22 22:33 23:44; done in cycle 5; mem_read stays 0.
- Wrap: load at base 0xFE → addresses FE, FF, 00, 01. With the macro defined, addr_next=0x02 during done.
- start pulsed every cycle during a store, with altered base_addr and vdata_in → exactly one transfer with the original operands; busy stays high throughout.
- reset asserted in the cycle writing element 1 of a store → elements 2 and 3 are never written; done and vrf_write stay 0; all outputs 0 on the next cycle.

Source files
------------

// File: rtl/vec_mem_pkg.sv
// Shared types and constants for the vector memory sequencer.
package vec_mem_pkg;

  localparam int unsigned VEC_ELEMS  = 4;
  localparam int unsigned VEC_ELEM_W = 8;

  typedef logic [1:0] elem_idx_t;

  typedef enum logic [2:0] {
    StIdle,
    StLd,
    StLdDrain,
    StWb,
    StSt,
    StStDone
  } state_e;

endpackage

// File: rtl/vec_byte_slots.sv
// Four byte-wide slots with an indexed byte write, a whole-word load and an indexed byte read.
module vec_byte_slots
  import vec_mem_pkg::*;
(
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             wr_en_i,
  input  elem_idx_t                        wr_idx_i,
  input  logic [VEC_ELEM_W-1:0]            wr_data_i,
  input  logic                             load_all_i,
  input  logic [VEC_ELEMS*VEC_ELEM_W-1:0]  load_data_i,
  input  elem_idx_t                        rd_idx_i,
  output logic [VEC_ELEM_W-1:0]            rd_data_o,
  output logic [VEC_ELEMS*VEC_ELEM_W-1:0]  word_o
);

  logic [VEC_ELEMS-1:0][VEC_ELEM_W-1:0] slots_q, slots_d;

  always_comb begin
    slots_d = slots_q;
    if (load_all_i) begin
      slots_d = load_data_i;
    end else if (wr_en_i) begin
      slots_d[wr_idx_i] = wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slots_q <= '0;
    end else begin
      slots_q <= slots_d;
    end
  end

  assign rd_data_o = slots_q[rd_idx_i];
  assign word_o    = slots_q;

endmodule

// File: rtl/vec_mem_seq.sv
// Byte-serial vector load/store sequencer between the control FSM and an 8-bit data memory.
// Optional post-increment outputs are built when VEC_MEM_SEQ_POSTINC_EN is defined.
module vec_mem_seq
  import vec_mem_pkg::*;
#(
  parameter int unsigned ELEMS  = VEC_ELEMS,
  parameter int unsigned ELEM_W = VEC_ELEM_W
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    op_store,
  input  logic [ELEM_W-1:0]       base_addr,
  input  logic [ELEMS*ELEM_W-1:0] vdata_in,
  input  logic [ELEM_W-1:0]       mem_q,
  output logic [ELEM_W-1:0]       mem_addr,
  output logic                    mem_read,
  output logic                    mem_wren,
  output logic [ELEM_W-1:0]       mem_data,
  output logic [ELEMS*ELEM_W-1:0] vdata_out,
  output logic                    vrf_write,
  output logic                    busy,
  output logic                    done
`ifdef VEC_MEM_SEQ_POSTINC_EN
  ,
  output logic [ELEM_W-1:0]       addr_next,
  output logic [0:0]              addr_wb
`endif
);

  localparam elem_idx_t LastIdx = elem_idx_t'(ELEMS - 1);

  state_e              state_q, state_d;
  elem_idx_t           idx_q, idx_d;
  logic [ELEM_W-1:0]   base_q, base_d;

  logic                ld_we;
  elem_idx_t           ld_idx;
  logic                st_load;
  logic [ELEM_W-1:0]   st_byte;
  logic [ELEM_W-1:0]   ld_rd_unused;
  logic [ELEMS*ELEM_W-1:0] st_word_unused;
  logic [ELEM_W-1:0]   cur_addr;

  assign cur_addr = base_q + ELEM_W'(idx_q);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    base_d    = base_q;
    mem_addr  = '0;
    mem_read  = 1'b0;
    mem_wren  = 1'b0;
    mem_data  = '0;
    vrf_write = 1'b0;
    done      = 1'b0;
    ld_we     = 1'b0;
    ld_idx    = idx_q - 2'd1;
    st_load   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          base_d  = base_addr;
          idx_d   = '0;
          st_load = 1'b1;
          state_d = op_store ? StSt : StLd;
        end
      end
      StLd: begin
        mem_read = 1'b1;
        mem_addr = cur_addr;
        // Read data lags the address by a cycle, so byte idx-1 lands now.
        ld_we    = (idx_q != '0);
        idx_d    = idx_q + 2'd1;
        if (idx_q == LastIdx) state_d = StLdDrain;
      end
      StLdDrain: begin
        ld_we   = 1'b1;
        ld_idx  = LastIdx;
        state_d = StWb;
      end
      StWb: begin
        vrf_write = 1'b1;
        done      = 1'b1;
        state_d   = StIdle;
      end
      StSt: begin
        mem_wren = 1'b1;
        mem_addr = cur_addr;
        mem_data = st_byte;
        idx_d    = idx_q + 2'd1;
        if (idx_q == LastIdx) state_d = StStDone;
      end
      StStDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      base_q  <= base_d;
    end
  end

  assign busy = (state_q != StIdle);

  vec_byte_slots u_ld_slots (
    .clk_i       (clock),
    .rst_i       (reset),
    .wr_en_i     (ld_we),
    .wr_idx_i    (ld_idx),
    .wr_data_i   (mem_q),
    .load_all_i  (1'b0),
    .load_data_i ('0),
    .rd_idx_i    ('0),
    .rd_data_o   (ld_rd_unused),
    .word_o      (vdata_out)
  );

  vec_byte_slots u_st_slots (
    .clk_i       (clock),
    .rst_i       (reset),
    .wr_en_i     (1'b0),
    .wr_idx_i    ('0),
    .wr_data_i   ('0),
    .load_all_i  (st_load),
    .load_data_i (vdata_in),
    .rd_idx_i    (idx_q),
    .rd_data_o   (st_byte),
    .word_o      (st_word_unused)
  );

`ifdef VEC_MEM_SEQ_POSTINC_EN
  assign addr_next = done ? (base_q + ELEM_W'(ELEMS)) : '0;
  assign addr_wb   = done;
`endif

endmodule
